// File: rtl/obuf_rd_pkg.sv
// Shared types and constants for the output-buffer memory reader.
package obuf_rd_pkg;

  // Controller states; encoding is fixed so waveforms stay comparable across revisions.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Pointer width for a power-of-two FIFO; a depth of one still gets a 1-bit pointer.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of the occupancy/credit counters is FIFO_PTR_W+1 so a full FIFO is representable.
  localparam int unsigned FIFO_PTR_W = fifo_ptr_w(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/obuf_rd_fifo.sv
// First-word-fall-through capture FIFO for read data returning from the output buffer.
module obuf_rd_fifo
  import obuf_rd_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointer and occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; a reset empties the FIFO by rewinding the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Head of queue and status flags.
  always_comb begin
    head_data = mem_q[rd_ptr_q];
    count     = count_q;
    empty     = (count_q == '0);
  end

  // Issue-side credit accounting must make both of these unreachable.
  assert property (@(posedge clk) disable iff (reset) !(push && !pop && count_q == FullCnt));
  assert property (@(posedge clk) disable iff (reset) !(pop && count_q == '0));

endmodule

// File: rtl/obuf_mem_reader.sv
// Drain-side reader: turns one (base, count) command into output-buffer reads and streams
// the returned words out on a valid/ready interface.
module obuf_mem_reader
  import obuf_rd_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [CNT_W-1:0]          cmd_num_words,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [MEM_DATA_WIDTH-1:0] m_data,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned PtrW = fifo_ptr_w(FIFO_DEPTH);
  localparam logic [PtrW+1:0] CreditMax = (PtrW + 2)'(FIFO_DEPTH);

  rd_state_e state_q, state_d;

  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]          issue_rem_q, issue_rem_d;
  logic [CNT_W-1:0]          out_rem_q, out_rem_d;
  logic [READ_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

  logic                      accept;
  logic                      issue;
  logic                      have_credit;
  logic                      push;
  logic                      pop;
  logic                      drain_done;
  logic                      fifo_empty;
  logic [PtrW:0]             fifo_count;
  logic [PtrW:0]             inflight;
  logic [PtrW+1:0]           credit_used;
  logic [MEM_DATA_WIDTH-1:0] head_data;

  // Credit: a read goes out only if its data is guaranteed a FIFO slot on return.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + (PtrW + 1)'(rd_pipe_q[i]);
    end
    credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    have_credit = (credit_used < CreditMax);
  end

  // Handshake and datapath strobes shared by the FSM and the counters.
  always_comb begin
    accept     = (state_q == IDLE) && cmd_valid;
    issue      = (state_q == ISSUE) && (issue_rem_q != '0) && have_credit;
    push       = rd_pipe_q[READ_LATENCY-1];
    pop        = !fifo_empty && m_ready;
    drain_done = (state_q == DRAIN) && (out_rem_q == '0) && (inflight == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (cmd_num_words == '0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        if (issue_rem_q == '0 || (issue && issue_rem_q == CNT_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and stream outputs; the stream view is the FIFO head plus the remaining-word count.
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    done          = drain_done;
    mem_read_req  = issue;
    mem_read_addr = issue ? addr_q : '0;
    m_valid       = !fifo_empty;
    m_data        = head_data;
    m_last        = !fifo_empty && (out_rem_q == CNT_W'(1));
  end

  // Address/count bookkeeping and the read-return shift register.
  always_comb begin
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    if (accept) begin
      addr_d      = cmd_base_addr;
      issue_rem_d = cmd_num_words;
      out_rem_d   = cmd_num_words;
    end else begin
      if (issue) begin
        addr_d      = addr_q + MEM_ADDR_WIDTH'(1);
        issue_rem_d = issue_rem_q - CNT_W'(1);
      end
      if (pop) out_rem_d = out_rem_q - CNT_W'(1);
    end
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = issue;
  end

  // Datapath registers; clearing rd_pipe_q on reset drops any data still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      rd_pipe_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  obuf_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MEM_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_read_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
